// File: rtl/tdm_pkg.sv
// Types shared by the TDM receive demultiplexer and the future transmit multiplexer.
package tdm_pkg;

    localparam int NUM_CH = 4;

    typedef logic [1:0] slot_t;

    typedef enum logic {
        HUNT  = 1'b0,
        TRACK = 1'b1
    } tdm_state_e;

endpackage

// File: rtl/tdm_demux_4ch.sv
// Four-channel TDM demultiplexer: aligns to start-of-frame, steers samples to
// per-channel holding registers and reports frame delivery, lock and alignment errors.
module tdm_demux_4ch
    import tdm_pkg::*;
#(
    parameter int DATA_W      = 16,
    parameter int LOCK_FRAMES = 2
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           in_valid,
    input  logic                           in_sof,
    input  logic [DATA_W-1:0]              in_data,
    output logic [NUM_CH-1:0][DATA_W-1:0]  ch_data,
    output logic [NUM_CH-1:0]              ch_valid,
    output logic                           frame_valid,
    output logic [1:0]                     slot,
    output logic                           locked,
    output logic                           sync_err
);

    localparam logic [3:0] LOCK_CNT = 4'(LOCK_FRAMES);

    tdm_state_e state;
    slot_t      cur_slot;
    logic [3:0] good_cnt;
    logic [3:0] good_cnt_inc;

    assign slot = cur_slot;

    // Saturating increment so the counter parks at the lock threshold.
    always_comb begin
        good_cnt_inc = good_cnt;
        if (good_cnt != LOCK_CNT) begin
            good_cnt_inc = good_cnt + 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= HUNT;
            cur_slot    <= '0;
            good_cnt    <= '0;
            locked      <= 1'b0;
            ch_data     <= '0;
            ch_valid    <= '0;
            frame_valid <= 1'b0;
            sync_err    <= 1'b0;
        end else begin
            ch_valid    <= '0;
            frame_valid <= 1'b0;
            sync_err    <= 1'b0;
            if (in_valid) begin
                unique case (state)
                    HUNT: begin
                        if (in_sof) begin
                            ch_data[0]  <= in_data;
                            ch_valid[0] <= 1'b1;
                            cur_slot    <= 2'd1;
                            state       <= TRACK;
                        end
                    end
                    TRACK: begin
                        if (in_sof && cur_slot != 2'd0) begin
                            // Early SOF: resynchronise on this sample as a fresh slot 0.
                            sync_err    <= 1'b1;
                            ch_data[0]  <= in_data;
                            ch_valid[0] <= 1'b1;
                            cur_slot    <= 2'd1;
                            good_cnt    <= '0;
                            locked      <= 1'b0;
                        end else if (!in_sof && cur_slot == 2'd0) begin
                            // Missing SOF: alignment is lost, drop the sample and hunt again.
                            sync_err <= 1'b1;
                            good_cnt <= '0;
                            locked   <= 1'b0;
                            state    <= HUNT;
                        end else begin
                            ch_data[cur_slot]  <= in_data;
                            ch_valid[cur_slot] <= 1'b1;
                            cur_slot           <= cur_slot + 2'd1;
                            if (cur_slot == 2'd3) begin
                                frame_valid <= 1'b1;
                                good_cnt    <= good_cnt_inc;
                                locked      <= (good_cnt_inc == LOCK_CNT);
                            end
                        end
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_tdm_demux_4ch.sv
// Randomized self-checking bench for tdm_demux_4ch against a slot-rule reference model.
module tb_tdm_demux_4ch;

    localparam int DATA_W = 16;
    localparam int LOCK   = 2;
    localparam int BUS_W  = 4 * DATA_W + 4 + 1 + 2 + 1 + 1;

    logic                    clk = 1'b0;
    logic                    rst;
    logic                    in_valid;
    logic                    in_sof;
    logic [DATA_W-1:0]       in_data;
    logic [3:0][DATA_W-1:0]  ch_data;
    logic [3:0]              ch_valid;
    logic                    frame_valid;
    logic [1:0]              slot;
    logic                    locked;
    logic                    sync_err;

    tdm_demux_4ch #(.DATA_W(DATA_W), .LOCK_FRAMES(LOCK)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_sof(in_sof), .in_data(in_data),
        .ch_data(ch_data), .ch_valid(ch_valid), .frame_valid(frame_valid),
        .slot(slot), .locked(locked), .sync_err(sync_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: channel contents, next slot, hunting flag, good-frame tally.
    logic [3:0][DATA_W-1:0] m_data;
    int                     m_slot;
    bit                     m_hunt;
    int                     m_good;
    logic [3:0]             e_cv;
    bit                     e_fv;
    bit                     e_se;

    wire  [BUS_W-1:0] act_bus = {ch_data, ch_valid, frame_valid, slot, locked, sync_err};
    logic [BUS_W-1:0] exp_bus;

    function automatic logic [BUS_W-1:0] pack_exp();
        logic [1:0] s = 2'(m_slot);
        logic       l = (m_good == LOCK);
        return {m_data, e_cv, e_fv, s, l, e_se};
    endfunction

    task automatic model_reset();
        m_data  = '0;
        m_slot  = 0;
        m_hunt  = 1'b1;
        m_good  = 0;
        e_cv    = '0;
        e_fv    = 1'b0;
        e_se    = 1'b0;
        exp_bus = pack_exp();
    endtask

    task automatic model_accept(input int k, input logic [DATA_W-1:0] d);
        m_data[k] = d;
        e_cv[k]   = 1'b1;
        m_slot    = (k + 1) % 4;
    endtask

    task automatic model_step(input bit v, input bit sof, input logic [DATA_W-1:0] d);
        int k;
        e_cv = '0;
        e_fv = 1'b0;
        e_se = 1'b0;
        if (v) begin
            if (m_hunt) begin
                if (sof) begin
                    model_accept(0, d);
                    m_hunt = 1'b0;
                end
            end else if (sof && m_slot != 0) begin
                e_se   = 1'b1;
                m_good = 0;
                model_accept(0, d);
            end else if (!sof && m_slot == 0) begin
                e_se   = 1'b1;
                m_good = 0;
                m_hunt = 1'b1;
            end else begin
                k = m_slot;
                model_accept(k, d);
                if (k == 3) begin
                    e_fv   = 1'b1;
                    m_good = (m_good + 1 > LOCK) ? LOCK : m_good + 1;
                end
            end
        end
        exp_bus = pack_exp();
    endtask

    // One clock: present inputs, let the edge happen, advance the model, settle.
    task automatic cyc(input bit v, input bit sof, input logic [DATA_W-1:0] d);
        in_valid = v;
        in_sof   = sof;
        in_data  = d;
        @(posedge clk);
        model_step(v, sof, d);
        #1;
        in_valid = 1'b0;
        in_sof   = 1'b0;
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        in_valid = 1'b0;
        in_sof   = 1'b0;
        in_data  = '0;
        @(posedge clk);
        @(posedge clk);
        model_reset();
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++;
        if (act_bus !== {BUS_W{1'b0}} || act_bus !== exp_bus)
            $display("FAIL reset_state: got %h expected %h", act_bus, exp_bus);
        else n_pass++;
    endtask

    task automatic test_single_frame();
        logic [3:0] walk;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            cyc(1'b1, i == 0, 16'h0010 + 16'(i));
            walk = 4'b0001 << i;
            n_checks++;
            if (act_bus !== exp_bus || ch_valid !== walk || ch_data[i] !== 16'h0010 + 16'(i))
                $display("FAIL single_frame_s%0d: got cv=%b d=%h bus=%h expected cv=%b bus=%h",
                         i, ch_valid, ch_data[i], act_bus, walk, exp_bus);
            else n_pass++;
        end
        n_checks++;
        if (frame_valid !== 1'b1 || locked !== 1'b0)
            $display("FAIL single_frame_fv: got fv=%b locked=%b expected fv=1 locked=0", frame_valid, locked);
        else n_pass++;
    endtask

    task automatic test_lock();
        do_reset();
        for (int f = 0; f < 3; f++) begin
            for (int i = 0; i < 4; i++) begin
                cyc(1'b1, i == 0, 16'($urandom));
                n_checks++;
                if (act_bus !== exp_bus)
                    $display("FAIL lock_f%0d_s%0d: got %h expected %h", f, i, act_bus, exp_bus);
                else n_pass++;
            end
            n_checks++;
            if (locked !== (f >= 1) || frame_valid !== 1'b1)
                $display("FAIL lock_after_f%0d: got locked=%b fv=%b expected locked=%b fv=1",
                         f, locked, frame_valid, f >= 1);
            else n_pass++;
        end
    endtask

    task automatic test_hunt();
        do_reset();
        for (int i = 0; i < 5; i++) begin
            cyc(1'b1, 1'b0, 16'($urandom));
            n_checks++;
            if (ch_valid !== 4'b0000 || sync_err !== 1'b0 || act_bus !== exp_bus)
                $display("FAIL hunt_discard%0d: got cv=%b se=%b expected cv=0000 se=0", i, ch_valid, sync_err);
            else n_pass++;
        end
        for (int i = 0; i < 4; i++) begin
            cyc(1'b1, i == 0, 16'h0A00 + 16'(i));
            n_checks++;
            if (act_bus !== exp_bus)
                $display("FAIL hunt_frame_s%0d: got %h expected %h", i, act_bus, exp_bus);
            else n_pass++;
        end
    endtask

    task automatic test_early_sof();
        do_reset();
        for (int i = 0; i < 8; i++) cyc(1'b1, (i % 4) == 0, 16'($urandom));
        cyc(1'b1, 1'b1, 16'h0B00);
        cyc(1'b1, 1'b0, 16'h0B01);
        cyc(1'b1, 1'b1, 16'h0B02);
        n_checks++;
        if (sync_err !== 1'b1 || ch_valid !== 4'b0001 || locked !== 1'b0 || slot !== 2'd1 ||
            frame_valid !== 1'b0 || ch_data[0] !== 16'h0B02 || act_bus !== exp_bus)
            $display("FAIL early_sof: got se=%b cv=%b lk=%b slot=%0d fv=%b expected se=1 cv=0001 lk=0 slot=1 fv=0",
                     sync_err, ch_valid, locked, slot, frame_valid);
        else n_pass++;
        for (int i = 1; i < 4; i++) begin
            cyc(1'b1, 1'b0, 16'($urandom));
            n_checks++;
            if (act_bus !== exp_bus)
                $display("FAIL early_sof_resume%0d: got %h expected %h", i, act_bus, exp_bus);
            else n_pass++;
        end
    endtask

    task automatic test_missing_sof();
        logic [3:0][DATA_W-1:0] snap;
        do_reset();
        for (int i = 0; i < 8; i++) cyc(1'b1, (i % 4) == 0, 16'($urandom));
        snap = ch_data;
        cyc(1'b1, 1'b0, 16'hDEAD);
        n_checks++;
        if (sync_err !== 1'b1 || ch_valid !== 4'b0000 || ch_data !== snap || locked !== 1'b0 ||
            act_bus !== exp_bus)
            $display("FAIL missing_sof: got se=%b cv=%b lk=%b expected se=1 cv=0000 lk=0 data held",
                     sync_err, ch_valid, locked);
        else n_pass++;
        cyc(1'b1, 1'b0, 16'hBEEF);
        n_checks++;
        if (sync_err !== 1'b0 || ch_valid !== 4'b0000 || act_bus !== exp_bus)
            $display("FAIL missing_sof_hunt: got se=%b cv=%b expected se=0 cv=0000", sync_err, ch_valid);
        else n_pass++;
    endtask

    task automatic test_gaps();
        int gap;
        for (int g = 0; g < 2; g++) begin
            gap = (g == 0) ? 1 : 3;
            do_reset();
            for (int i = 0; i < 4; i++) begin
                if (i == 2) begin
                    for (int j = 0; j < gap; j++) begin
                        cyc(1'b0, 1'b0, 16'($urandom));
                        n_checks++;
                        if (ch_valid !== 4'b0000 || act_bus !== exp_bus)
                            $display("FAIL gap%0d_idle%0d: got %h expected %h", gap, j, act_bus, exp_bus);
                        else n_pass++;
                    end
                end
                cyc(1'b1, i == 0, 16'h0C10 + 16'(i));
            end
            n_checks++;
            if (frame_valid !== 1'b1 || ch_data !== {16'h0C13, 16'h0C12, 16'h0C11, 16'h0C10} ||
                act_bus !== exp_bus)
                $display("FAIL gap%0d_frame: got fv=%b data=%h expected fv=1 data=0c130c120c110c10",
                         gap, frame_valid, ch_data);
            else n_pass++;
        end
    endtask

    task automatic test_reset_midframe();
        do_reset();
        cyc(1'b1, 1'b1, 16'h1111);
        cyc(1'b1, 1'b0, 16'h2222);
        rst = 1'b1;
        cyc(1'b1, 1'b0, 16'h3333);
        model_reset();
        rst = 1'b0;
        n_checks++;
        if (act_bus !== {BUS_W{1'b0}})
            $display("FAIL reset_midframe: got %h expected 0", act_bus);
        else n_pass++;
    endtask

    task automatic test_random();
        bit v, sof;
        do_reset();
        for (int c = 0; c < 600; c++) begin
            v   = ($urandom_range(0, 99) < 75);
            sof = (m_hunt || m_slot == 0);
            if ($urandom_range(0, 99) < 8) sof = !sof;
            cyc(v, sof, 16'($urandom));
            n_checks++;
            if (act_bus !== exp_bus || (sync_err && frame_valid) || !$onehot0(ch_valid))
                $display("FAIL random_c%0d: got %h expected %h", c, act_bus, exp_bus);
            else n_pass++;
        end
    endtask

    initial begin
        rst      = 1'b1;
        in_valid = 1'b0;
        in_sof   = 1'b0;
        in_data  = '0;
        model_reset();
        test_reset();
        test_single_frame();
        test_lock();
        test_hunt();
        test_early_sof();
        test_missing_sof();
        test_gaps();
        test_reset_midframe();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
